// File: rtl/gs_mem_arbiter_if.sv
// Bundles the fetch, load/store and memory-side signals of gs_mem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding core/memory.
interface gs_mem_arbiter_if #(
  parameter int ADDR_SIZE = 32,
  parameter int WORD_SIZE = 32,
  parameter int BYTES     = 4
);
  logic                 if_req_i;
  logic [ADDR_SIZE-1:0] if_addr_i;
  logic                 if_gnt_o;
  logic                 if_rvalid_o;
  logic [WORD_SIZE-1:0] if_rdata_o;
  logic                 if_flush_i;

  logic                 ls_req_i;
  logic                 ls_we_i;
  logic [ADDR_SIZE-1:0] ls_addr_i;
  logic [WORD_SIZE-1:0] ls_wdata_i;
  logic [BYTES-1:0]     ls_be_i;
  logic                 ls_gnt_o;
  logic                 ls_rvalid_o;
  logic [WORD_SIZE-1:0] ls_rdata_o;
  logic                 ls_busy_o;

  logic                 mem_req_o;
  logic                 mem_we_o;
  logic [ADDR_SIZE-1:0] mem_addr_o;
  logic [WORD_SIZE-1:0] mem_wdata_o;
  logic [BYTES-1:0]     mem_be_o;
  logic                 mem_gnt_i;
  logic                 mem_rvalid_i;
  logic [WORD_SIZE-1:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i, if_flush_i,
           ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_be_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o,
           ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_busy_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
  );

  modport master (
    output if_req_i, if_addr_i, if_flush_i,
           ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_be_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o,
           ls_gnt_o, ls_rvalid_o, ls_rdata_o, ls_busy_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
  );
endinterface

// File: rtl/gs_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and LSU (LSU priority).
// Define GS_ARB_FAIRNESS_EN to add a starvation counter that forces a fetch grant.
module gs_mem_arbiter #(
  parameter int ADDR_SIZE    = 32,
  parameter int WORD_SIZE    = 32,
  parameter int BYTES        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input logic            clk,
  input logic            rst,
  gs_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

  state_t               state, state_nxt;
  logic                 owner_ls;
  logic                 drop;
  logic                 mem_we_q;
  logic [ADDR_SIZE-1:0] mem_addr_q;
  logic [WORD_SIZE-1:0] mem_wdata_q;
  logic [BYTES-1:0]     mem_be_q;

  logic force_fetch;
  logic fetch_win;
  logic if_gnt, ls_gnt;
  logic complete;
  logic if_rvalid, ls_rvalid;

  if (STARVE_LIMIT < 1) begin : g_limit_check
    // A limit below one would force fetch on every arbitration.
  end

`ifdef GS_ARB_FAIRNESS_EN
  localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;
  logic [CNT_W-1:0] starve_cnt;

  assign force_fetch = (starve_cnt >= CNT_W'(STARVE_LIMIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (if_gnt) begin
      starve_cnt <= '0;
    end else if (ls_gnt && bus.if_req_i) begin
      if (starve_cnt != '1) starve_cnt <= starve_cnt + 1'b1;
    end else if (state == ST_IDLE && !bus.if_req_i) begin
      starve_cnt <= '0;
    end
  end
`else
  assign force_fetch = 1'b0;
`endif

  assign fetch_win = bus.if_req_i & (~bus.ls_req_i | force_fetch);

  always_comb begin
    state_nxt = state;
    if_gnt    = 1'b0;
    ls_gnt    = 1'b0;
    complete  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fetch_win) begin
          if_gnt    = 1'b1;
          state_nxt = ST_REQ;
        end else if (bus.ls_req_i) begin
          ls_gnt    = 1'b1;
          state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.mem_gnt_i) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mem_rvalid_i) begin
          complete  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      owner_ls    <= 1'b1;
      drop        <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state <= state_nxt;
      if (if_gnt || ls_gnt) begin
        owner_ls    <= ls_gnt;
        mem_we_q    <= ls_gnt & bus.ls_we_i;
        mem_addr_q  <= ls_gnt ? bus.ls_addr_i : bus.if_addr_i;
        mem_wdata_q <= ls_gnt ? bus.ls_wdata_i : '0;
        mem_be_q    <= ls_gnt ? bus.ls_be_i : '1;
      end
      // A flushed fetch still completes at memory; only its response is hidden.
      if (state_nxt == ST_IDLE) begin
        drop <= 1'b0;
      end else if (state != ST_IDLE && !owner_ls && bus.if_flush_i) begin
        drop <= 1'b1;
      end
    end
  end

  assign ls_rvalid = complete & owner_ls;
  assign if_rvalid = complete & ~owner_ls & ~drop & ~bus.if_flush_i;

  assign bus.if_gnt_o    = if_gnt;
  assign bus.ls_gnt_o    = ls_gnt;
  assign bus.if_rvalid_o = if_rvalid;
  assign bus.ls_rvalid_o = ls_rvalid;
  assign bus.if_rdata_o  = if_rvalid ? bus.mem_rdata_i : '0;
  assign bus.ls_rdata_o  = ls_rvalid ? bus.mem_rdata_i : '0;
  assign bus.ls_busy_o   = owner_ls & (state != ST_IDLE);
  assign bus.mem_req_o   = (state == ST_REQ);
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
  assign bus.mem_be_o    = mem_be_q;

endmodule

// File: tb/tb_gs_mem_arbiter.sv
// Bench for gs_mem_arbiter: fixed vector table, directed corner sequences,
// and random traffic checked against a transaction-level reference model.
module tb_gs_mem_arbiter;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gs_mem_arbiter_if #(.ADDR_SIZE(32), .WORD_SIZE(32), .BYTES(4)) bus ();

  gs_mem_arbiter #(.ADDR_SIZE(32), .WORD_SIZE(32), .BYTES(4), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: one optional outstanding transaction.
  bit          m_busy, m_acc, m_own_ls, m_drop, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  int          m_starve;
  bit          e_ls_gnt, e_if_gnt;

  typedef struct {
    bit          ls_req, if_req, mem_gnt, mem_rv;
    logic [31:0] addr, rdata;
    bit          e_ls_gnt, e_if_gnt, e_mem_req, e_ls_rv, e_if_rv, e_busy;
    logic [31:0] e_mem_addr, e_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_acc = 0; m_own_ls = 1; m_drop = 0; m_we = 0;
    m_addr = '0; m_wdata = '0; m_be = '0; m_starve = 0;
  endtask

  task automatic clear_inputs();
    bus.if_req_i = 0; bus.if_addr_i = '0; bus.if_flush_i = 0;
    bus.ls_req_i = 0; bus.ls_we_i = 0; bus.ls_addr_i = '0; bus.ls_wdata_i = '0; bus.ls_be_i = '0;
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = '0;
  endtask

  // Compare all outputs against the model, then advance the model by one clock.
  task automatic check_model();
    bit fw, force_f, complete, lsr, ifr;
    force_f = 0;
`ifdef GS_ARB_FAIRNESS_EN
    force_f = (m_starve >= LIMIT);
`endif
    fw       = !m_busy && bus.if_req_i && (!bus.ls_req_i || force_f);
    e_if_gnt = fw;
    e_ls_gnt = !m_busy && bus.ls_req_i && !fw;
    complete = m_busy && m_acc && bus.mem_rvalid_i;
    lsr      = complete && m_own_ls;
    ifr      = complete && !m_own_ls && !m_drop && !bus.if_flush_i;

    chk("ls_gnt",    bus.ls_gnt_o,    e_ls_gnt);
    chk("if_gnt",    bus.if_gnt_o,    e_if_gnt);
    chk("mem_req",   bus.mem_req_o,   m_busy && !m_acc);
    chk("mem_we",    bus.mem_we_o,    m_we);
    chk("mem_addr",  bus.mem_addr_o,  m_addr);
    chk("mem_wdata", bus.mem_wdata_o, m_wdata);
    chk("mem_be",    bus.mem_be_o,    m_be);
    chk("ls_rvalid", bus.ls_rvalid_o, lsr);
    chk("ls_rdata",  bus.ls_rdata_o,  lsr ? bus.mem_rdata_i : 32'h0);
    chk("if_rvalid", bus.if_rvalid_o, ifr);
    chk("if_rdata",  bus.if_rdata_o,  ifr ? bus.mem_rdata_i : 32'h0);
    chk("ls_busy",   bus.ls_busy_o,   m_busy && m_own_ls);

    if (!m_busy) begin
`ifdef GS_ARB_FAIRNESS_EN
      if (e_if_gnt) m_starve = 0;
      else if (e_ls_gnt && bus.if_req_i) m_starve = (m_starve < 7) ? m_starve + 1 : 7;
      else if (!bus.if_req_i) m_starve = 0;
`endif
      if (e_ls_gnt || e_if_gnt) begin
        m_busy = 1; m_acc = 0; m_drop = 0; m_own_ls = e_ls_gnt;
        m_we    = e_ls_gnt ? bus.ls_we_i : 1'b0;
        m_addr  = e_ls_gnt ? bus.ls_addr_i : bus.if_addr_i;
        m_wdata = e_ls_gnt ? bus.ls_wdata_i : 32'h0;
        m_be    = e_ls_gnt ? bus.ls_be_i : 4'hf;
      end
    end else if (complete) begin
      m_busy = 0; m_drop = 0;
    end else begin
      if (!m_acc && bus.mem_gnt_i) m_acc = 1;
      if (!m_own_ls && bus.if_flush_i) m_drop = 1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_model();
    @(posedge clk);
    #1;
  endtask

  // Drive an already-granted transaction through memory accept and response.
  task automatic finish_txn(input logic [31:0] rdata);
    bus.mem_gnt_i = 1; step();
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = rdata; step();
    bus.mem_rvalid_i = 0; bus.mem_rdata_i = '0;
  endtask

  initial begin
    vec_t tbl[$];
    bit lsp, ifp;

    tbl.push_back('{1,0,0,0, 32'h100, 0,          1,0,0,0,0,0, 32'h000, 32'h0});
    tbl.push_back('{0,0,0,0, 32'h000, 0,          0,0,1,0,0,1, 32'h100, 32'h0});
    tbl.push_back('{0,0,0,0, 32'h000, 0,          0,0,1,0,0,1, 32'h100, 32'h0});
    tbl.push_back('{0,0,1,0, 32'h000, 0,          0,0,1,0,0,1, 32'h100, 32'h0});
    tbl.push_back('{0,0,0,0, 32'h000, 0,          0,0,0,0,0,1, 32'h100, 32'h0});
    tbl.push_back('{0,0,0,1, 32'h000, 32'hDEADBEEF, 0,0,0,1,0,1, 32'h100, 32'hDEADBEEF});
    tbl.push_back('{0,1,0,0, 32'h200, 0,          0,1,0,0,0,0, 32'h100, 32'h0});
    tbl.push_back('{0,0,1,1, 32'h000, 32'h55,     0,0,1,0,0,0, 32'h200, 32'h0});
    tbl.push_back('{0,0,0,1, 32'h000, 32'hCAFEF00D, 0,0,0,0,1,0, 32'h200, 32'hCAFEF00D});
    tbl.push_back('{1,1,0,0, 32'h300, 0,          1,0,0,0,0,0, 32'h200, 32'h0});
    tbl.push_back('{0,1,1,0, 32'h300, 0,          0,0,1,0,0,1, 32'h300, 32'h0});
    tbl.push_back('{0,1,0,1, 32'h300, 32'h77,     0,0,0,1,0,1, 32'h300, 32'h77});
    tbl.push_back('{0,1,0,0, 32'h300, 0,          0,1,0,0,0,0, 32'h300, 32'h0});

    // Reset state
    rst = 1;
    clear_inputs();
    model_reset();
    #12;
    chk("rst_mem_req",  bus.mem_req_o,  0);
    chk("rst_mem_addr", bus.mem_addr_o, 0);
    chk("rst_mem_be",   bus.mem_be_o,   0);
    chk("rst_busy",     bus.ls_busy_o,  0);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;

    // Table-driven vectors
    foreach (tbl[i]) begin
      bus.ls_req_i = tbl[i].ls_req; bus.if_req_i = tbl[i].if_req;
      bus.ls_addr_i = tbl[i].addr;  bus.if_addr_i = tbl[i].addr;
      bus.ls_we_i = 0; bus.ls_wdata_i = '0; bus.ls_be_i = 4'hf;
      bus.mem_gnt_i = tbl[i].mem_gnt; bus.mem_rvalid_i = tbl[i].mem_rv; bus.mem_rdata_i = tbl[i].rdata;
      @(negedge clk);
      chk($sformatf("tv%0d_ls_gnt", i),   bus.ls_gnt_o,    tbl[i].e_ls_gnt);
      chk($sformatf("tv%0d_if_gnt", i),   bus.if_gnt_o,    tbl[i].e_if_gnt);
      chk($sformatf("tv%0d_mem_req", i),  bus.mem_req_o,   tbl[i].e_mem_req);
      chk($sformatf("tv%0d_ls_rv", i),    bus.ls_rvalid_o, tbl[i].e_ls_rv);
      chk($sformatf("tv%0d_if_rv", i),    bus.if_rvalid_o, tbl[i].e_if_rv);
      chk($sformatf("tv%0d_busy", i),     bus.ls_busy_o,   tbl[i].e_busy);
      chk($sformatf("tv%0d_mem_addr", i), bus.mem_addr_o,  tbl[i].e_mem_addr);
      chk($sformatf("tv%0d_rdata", i),    bus.ls_rdata_o | bus.if_rdata_o, tbl[i].e_rdata);
      check_model();
      @(posedge clk); #1;
    end
    clear_inputs();
    finish_txn(32'h0BAD0BAD);

    // Store held off by memory back-pressure
    bus.ls_req_i = 1; bus.ls_we_i = 1; bus.ls_addr_i = 32'h40;
    bus.ls_wdata_i = 32'h12345678; bus.ls_be_i = 4'h3;
    step();
    bus.ls_req_i = 0; bus.ls_we_i = 0; bus.ls_wdata_i = 32'hFFFFFFFF; bus.ls_be_i = 4'hC;
    for (int k = 0; k < 5; k++) begin
      chk("bp_mem_req",   bus.mem_req_o,   1);
      chk("bp_mem_we",    bus.mem_we_o,    1);
      chk("bp_mem_addr",  bus.mem_addr_o,  32'h40);
      chk("bp_mem_wdata", bus.mem_wdata_o, 32'h12345678);
      chk("bp_mem_be",    bus.mem_be_o,    4'h3);
      step();
    end
    bus.mem_gnt_i = 1; step();
    bus.mem_gnt_i = 0; step();
    bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h0;
    #1;
    chk("st_ack_rvalid", bus.ls_rvalid_o, 1);
    chk("st_ack_rdata",  bus.ls_rdata_o,  0);
    step();
    bus.mem_rvalid_i = 0;

    // Flushed fetch is dropped, next fetch is delivered
    bus.if_req_i = 1; bus.if_addr_i = 32'h200; step();
    bus.if_req_i = 0; bus.mem_gnt_i = 1; step();
    bus.mem_gnt_i = 0; bus.if_flush_i = 1; step();
    bus.if_flush_i = 0; step();
    bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hAAAA5555;
    #1;
    chk("flush_if_rvalid", bus.if_rvalid_o, 0);
    chk("flush_if_rdata",  bus.if_rdata_o,  0);
    step();
    bus.mem_rvalid_i = 0;
    bus.if_req_i = 1; bus.if_addr_i = 32'h204; step();
    bus.if_req_i = 0; bus.mem_gnt_i = 1; step();
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h1234;
    #1;
    chk("post_flush_if_rvalid", bus.if_rvalid_o, 1);
    chk("post_flush_if_rdata",  bus.if_rdata_o,  32'h1234);
    step();
    bus.mem_rvalid_i = 0;

    // Both requesters held: fetch wins only once the starvation limit is hit
    bus.if_req_i = 1; bus.ls_req_i = 1; bus.ls_addr_i = 32'h80; bus.if_addr_i = 32'h400;
    for (int k = 0; k <= LIMIT; k++) begin
`ifdef GS_ARB_FAIRNESS_EN
      chk($sformatf("fair_if_gnt%0d", k), bus.if_gnt_o, (k == LIMIT));
`else
      chk($sformatf("fair_if_gnt%0d", k), bus.if_gnt_o, 0);
`endif
      step();
      finish_txn(32'h100 + k);
    end
    clear_inputs();
    step();
    if (m_busy) finish_txn(32'h0);

    // Asynchronous reset in the middle of a load
    bus.ls_req_i = 1; bus.ls_addr_i = 32'h500; bus.ls_be_i = 4'hf; step();
    bus.ls_req_i = 0; bus.mem_gnt_i = 1; step();
    bus.mem_gnt_i = 0;
    chk("pre_rst_busy", bus.ls_busy_o, 1);
    #2;
    rst = 1; bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hFEEDFACE;
    #1;
    chk("arst_busy",     bus.ls_busy_o,   0);
    chk("arst_mem_req",  bus.mem_req_o,   0);
    chk("arst_mem_addr", bus.mem_addr_o,  0);
    chk("arst_mem_be",   bus.mem_be_o,    0);
    chk("arst_ls_rv",    bus.ls_rvalid_o, 0);
    chk("arst_ls_rdata", bus.ls_rdata_o,  0);
    model_reset();
    clear_inputs();
    @(posedge clk);
    @(negedge clk); rst = 0;
    @(posedge clk); #1;
    bus.ls_req_i = 1; bus.ls_addr_i = 32'h600; bus.ls_be_i = 4'hf;
    #1;
    chk("post_rst_ls_gnt", bus.ls_gnt_o, 1);
    step();
    bus.ls_req_i = 0;
    finish_txn(32'h6006);

    // Random traffic against the model
    lsp = 0; ifp = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!lsp && ($urandom % 3 == 0)) begin
        lsp = 1;
        bus.ls_we_i = 1'($urandom); bus.ls_addr_i = $urandom;
        bus.ls_wdata_i = $urandom; bus.ls_be_i = 4'($urandom);
      end
      if (!ifp && ($urandom % 3 == 0)) begin
        ifp = 1;
        bus.if_addr_i = $urandom;
      end
      bus.ls_req_i     = lsp;
      bus.if_req_i     = ifp;
      bus.if_flush_i   = ($urandom % 8 == 0);
      bus.mem_gnt_i    = 1'($urandom);
      bus.mem_rvalid_i = 1'($urandom);
      bus.mem_rdata_i  = $urandom;
      step();
      if (e_ls_gnt) lsp = 0;
      if (e_if_gnt) ifp = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
